// File: rtl/recip_norm_arbiter.sv
// Two-requester round-robin front end sharing one sign/magnitude + LZC normaliser.
// Optional macro RECIP_NORM_STATS_EN adds saturating acceptance/zero-result counters.
module recip_norm_arbiter #(
  parameter int WIDTH = 24,
  parameter int SHW   = 5
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_req0_valid,
  input  logic [WIDTH-1:0] i_req0_data,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [WIDTH-1:0] i_req1_data,
  output logic             o_req1_ready,
  output logic             o_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_mant,
  output logic [SHW-1:0]   o_shift,
  output logic             o_sign,
  output logic             o_zero,
`ifdef RECIP_NORM_STATS_EN
  output logic [15:0]      o_cnt0,
  output logic [15:0]      o_cnt1,
  output logic [15:0]      o_cnt_zero,
`endif
  output logic             o_id
);

`ifndef OPENLANE
  if (WIDTH != 24) begin : g_width_check
    $error("recip_norm_arbiter: WIDTH must be 24 to match the lzc");
  end
`endif

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Ready may depend on valid; valid must never depend on ready.

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_abs_q;
  logic             s1_sign_q;
  logic             s1_id_q;
  logic             last_grant_q, last_grant_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_mant_q;
  logic [SHW-1:0]   out_shift_q;
  logic             out_sign_q;
  logic             out_zero_q;
  logic             out_id_q;

  logic             adv2, load1;
  logic             any_grant, grant_id;
  logic [WIDTH-1:0] data_sel, abs_d;
  logic             sign_d;
  logic [SHW-1:0]   lzc_cnt;
  logic [WIDTH-1:0] mant_d;
  logic             zero_d;

  assign adv2  = !out_valid_q || i_out_ready;
  assign load1 = !s1_valid_q || adv2;

  // Contention goes to whichever requester did not win last.
  always_comb begin
    any_grant    = 1'b0;
    grant_id     = 1'b0;
    last_grant_d = last_grant_q;
    if (load1) begin
      if (i_req0_valid && i_req1_valid) begin
        any_grant = 1'b1;
        grant_id  = ~last_grant_q;
      end else if (i_req0_valid) begin
        any_grant = 1'b1;
        grant_id  = 1'b0;
      end else if (i_req1_valid) begin
        any_grant = 1'b1;
        grant_id  = 1'b1;
      end
    end
    if (any_grant) last_grant_d = grant_id;
  end

  assign o_req0_ready = any_grant && !grant_id;
  assign o_req1_ready = any_grant && grant_id;

  assign data_sel = grant_id ? i_req1_data : i_req0_data;
  assign sign_d   = data_sel[WIDTH-1];
  // Most-negative input wraps back to itself, read as unsigned 2^23.
  assign abs_d    = sign_d ? (~data_sel + {{(WIDTH-1){1'b0}}, 1'b1}) : data_sel;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    lzc_cnt = SHW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (s1_abs_q[i]) lzc_cnt = SHW'(WIDTH - 1 - i);
    end
  end

  assign mant_d = s1_abs_q << lzc_cnt;
  assign zero_d = (s1_abs_q == '0);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_grant_q <= 1'b1;
      s1_valid_q   <= 1'b0;
      s1_abs_q     <= '0;
      s1_sign_q    <= 1'b0;
      s1_id_q      <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      if (load1) begin
        s1_valid_q <= any_grant;
        if (any_grant) begin
          s1_abs_q  <= abs_d;
          s1_sign_q <= sign_d;
          s1_id_q   <= grant_id;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_valid_q <= 1'b0;
      out_mant_q  <= '0;
      out_shift_q <= '0;
      out_sign_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_id_q    <= 1'b0;
    end else if (adv2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_mant_q  <= mant_d;
        out_shift_q <= lzc_cnt;
        out_sign_q  <= s1_sign_q;
        out_zero_q  <= zero_d;
        out_id_q    <= s1_id_q;
      end
    end
  end

  assign o_valid = out_valid_q;
  assign o_mant  = out_mant_q;
  assign o_shift = out_shift_q;
  assign o_sign  = out_sign_q;
  assign o_zero  = out_zero_q;
  assign o_id    = out_id_q;

`ifdef RECIP_NORM_STATS_EN
  logic [15:0] cnt0_q, cnt1_q, cnt_zero_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      cnt_zero_q <= '0;
    end else begin
      if (i_req0_valid && o_req0_ready && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (i_req1_valid && o_req1_ready && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
      if (out_valid_q && i_out_ready && out_zero_q && cnt_zero_q != 16'hFFFF)
        cnt_zero_q <= cnt_zero_q + 16'd1;
    end
  end

  assign o_cnt0     = cnt0_q;
  assign o_cnt1     = cnt1_q;
  assign o_cnt_zero = cnt_zero_q;
`endif

endmodule

// File: tb/tb_recip_norm_arbiter.sv
// Directed bench for recip_norm_arbiter: normalisation table, alternation, backpressure, reset.
module tb_recip_norm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, out_ready;
  logic [23:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        o_valid, o_sign, o_zero, o_id;
  logic [23:0] o_mant;
  logic [4:0]  o_shift;
`ifdef RECIP_NORM_STATS_EN
  logic [15:0] cnt0, cnt1, cnt_zero;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  recip_norm_arbiter dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_req0_valid (req0_valid),
    .i_req0_data  (req0_data),
    .o_req0_ready (req0_ready),
    .i_req1_valid (req1_valid),
    .i_req1_data  (req1_data),
    .o_req1_ready (req1_ready),
    .o_valid      (o_valid),
    .i_out_ready  (out_ready),
    .o_mant       (o_mant),
    .o_shift      (o_shift),
    .o_sign       (o_sign),
    .o_zero       (o_zero),
`ifdef RECIP_NORM_STATS_EN
    .o_cnt0       (cnt0),
    .o_cnt1       (cnt1),
    .o_cnt_zero   (cnt_zero),
`endif
    .o_id         (o_id)
  );

  // id, data, mant, shift, sign, zero
  logic        nv_id   [8] = '{0, 1, 0, 0, 0, 0, 0, 1};
  logic [23:0] nv_data [8] = '{24'h001000, 24'hFFF000, 24'h800000, 24'h000000,
                               24'h000001, 24'h7FFFFF, 24'hFFFFFF, 24'h000300};
  logic [23:0] nv_mant [8] = '{24'h800000, 24'h800000, 24'h800000, 24'h000000,
                               24'h800000, 24'hFFFFFE, 24'h800000, 24'hC00000};
  logic [4:0]  nv_shift[8] = '{5'd11, 5'd11, 5'd0, 5'd24, 5'd23, 5'd1, 5'd23, 5'd14};
  logic        nv_sign [8] = '{0, 1, 1, 0, 0, 0, 1, 0};
  logic        nv_zero [8] = '{0, 0, 0, 1, 0, 0, 0, 0};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 0; req1_valid = 0; out_ready = 1;
    req0_data = '0; req1_data = '0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_vec++; if (o_mant !== 24'h0) begin n_err++; $display("FAIL reset_mant: got %h want 000000", o_mant); end
    n_vec++; if (o_shift !== 5'd0) begin n_err++; $display("FAIL reset_shift: got %0d want 0", o_shift); end
    n_vec++; if ({o_sign, o_zero, o_id} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {o_sign, o_zero, o_id}); end
    n_vec++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
`ifdef RECIP_NORM_STATS_EN
    n_vec++; if ({cnt0, cnt1, cnt_zero} !== 48'h0) begin n_err++; $display("FAIL reset_stats: got %h want 0", {cnt0, cnt1, cnt_zero}); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_back_to_back();
    req0_valid = 1; req0_data = 24'h000100;
    req1_valid = 1; req1_data = 24'hFFFF00;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (req0_ready !== (i % 2 == 0)) begin n_err++; $display("FAIL b2b_ready0[%0d]: got %b want %b", i, req0_ready, (i % 2 == 0)); end
      n_vec++; if (req1_ready !== (i % 2 == 1)) begin n_err++; $display("FAIL b2b_ready1[%0d]: got %b want %b", i, req1_ready, (i % 2 == 1)); end
      if (i >= 2) begin
        n_vec++; if ({o_valid, o_id, o_sign} !== {1'b1, 1'(i % 2), 1'(i % 2)})
          begin n_err++; $display("FAIL b2b_out[%0d]: got v/id/sign %b%b%b want 1%0d%0d", i, o_valid, o_id, o_sign, i % 2, i % 2); end
        n_vec++; if ({o_mant, o_shift} !== {24'h800000, 5'd15})
          begin n_err++; $display("FAIL b2b_norm[%0d]: got %h/%0d want 800000/15", i, o_mant, o_shift); end
      end
      step();
    end
    req0_valid = 0; req1_valid = 0;
    #1;
    n_vec++; if ({o_valid, o_id} !== 2'b10) begin n_err++; $display("FAIL b2b_tail0: got v/id %b%b want 10", o_valid, o_id); end
    step();
    n_vec++; if ({o_valid, o_id} !== 2'b11) begin n_err++; $display("FAIL b2b_tail1: got v/id %b%b want 11", o_valid, o_id); end
    step();
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", o_valid); end
  endtask

  task automatic test_normalise();
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      if (nv_id[k]) begin req1_valid = 1; req1_data = nv_data[k]; end
      else          begin req0_valid = 1; req0_data = nv_data[k]; end
      #1;
      n_vec++; if ({req0_ready, req1_ready} !== {~nv_id[k], nv_id[k]})
        begin n_err++; $display("FAIL norm_ready[%0d]: got %b%b want %b%b", k, req0_ready, req1_ready, ~nv_id[k], nv_id[k]); end
      step();
      req0_valid = 0; req1_valid = 0;
      #1;
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL norm_latency[%0d]: got valid %b after 1 edge want 0", k, o_valid); end
      step();
      n_vec++; if ({o_valid, o_id} !== {1'b1, nv_id[k]}) begin n_err++; $display("FAIL norm_valid[%0d]: got v/id %b%b want 1%b", k, o_valid, o_id, nv_id[k]); end
      n_vec++; if (o_mant !== nv_mant[k]) begin n_err++; $display("FAIL norm_mant[%0d]: got %h want %h", k, o_mant, nv_mant[k]); end
      n_vec++; if (o_shift !== nv_shift[k]) begin n_err++; $display("FAIL norm_shift[%0d]: got %0d want %0d", k, o_shift, nv_shift[k]); end
      n_vec++; if ({o_sign, o_zero} !== {nv_sign[k], nv_zero[k]})
        begin n_err++; $display("FAIL norm_flags[%0d]: got s/z %b%b want %b%b", k, o_sign, o_zero, nv_sign[k], nv_zero[k]); end
      step();
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL norm_drain[%0d]: got %b want 0", k, o_valid); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 0; req0_valid = 1; req0_data = 24'h001000;
    #1;
    n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_acc_a: got %b want 1", req0_ready); end
    step();
    req0_data = 24'h000001;
    #1;
    n_vec++; if ({req0_ready, o_valid} !== 2'b10) begin n_err++; $display("FAIL bp_acc_b: got rdy/v %b%b want 10", req0_ready, o_valid); end
    step();
    req0_data = 24'h000300;
    #1;
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall[%0d]: got ready %b want 0", c, req0_ready); end
      n_vec++; if ({o_valid, o_mant, o_shift, o_sign, o_id} !== {1'b1, 24'h800000, 5'd11, 1'b0, 1'b0})
        begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b mant=%h sh=%0d want 1/800000/11", c, o_valid, o_mant, o_shift); end
      if (c < 4) step();
    end
    out_ready = 1;
    #1;
    n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", req0_ready); end
    step();
    req0_valid = 0;
    #1;
    n_vec++; if ({o_valid, o_mant, o_shift} !== {1'b1, 24'h800000, 5'd23})
      begin n_err++; $display("FAIL bp_out_b: got v=%b mant=%h sh=%0d want 1/800000/23", o_valid, o_mant, o_shift); end
    step();
    n_vec++; if ({o_valid, o_mant, o_shift} !== {1'b1, 24'hC00000, 5'd14})
      begin n_err++; $display("FAIL bp_out_c: got v=%b mant=%h sh=%0d want 1/c00000/14", o_valid, o_mant, o_shift); end
    step();
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup: got %b want 0", o_valid); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 0; req0_valid = 1; req0_data = 24'h001000;
    step();
    step();
    req0_valid = 0;
    #1;
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL mid_inflight: got %b want 1", o_valid); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_clear: got %b want 0", o_valid); end
`ifdef RECIP_NORM_STATS_EN
    n_vec++; if ({cnt0, cnt1, cnt_zero} !== 48'h0) begin n_err++; $display("FAIL mid_stats: got %h want 0", {cnt0, cnt1, cnt_zero}); end
`endif
    step();
    rst_n = 1'b1;
    req0_valid = 1; req0_data = 24'h001000;
    req1_valid = 1; req1_data = 24'hFFF000;
    out_ready = 1;
    #1;
    n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL mid_first_grant: got %b want 10", {req0_ready, req1_ready}); end
    step();
    n_vec++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL mid_second_grant: got %b want 01", {req0_ready, req1_ready}); end
    step();
    req0_valid = 0; req1_valid = 0;
    #1;
    n_vec++; if ({o_valid, o_id, o_sign} !== 3'b100) begin n_err++; $display("FAIL mid_out0: got v/id/s %b%b%b want 100", o_valid, o_id, o_sign); end
    step();
    n_vec++; if ({o_valid, o_id, o_sign} !== 3'b111) begin n_err++; $display("FAIL mid_out1: got v/id/s %b%b%b want 111", o_valid, o_id, o_sign); end
    step();
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL mid_drain: got %b want 0", o_valid); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_normalise();
    test_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
